mem_stage: RTL
==============

# mem_stage

Memory-access (MEM) pipeline stage of the RV32IM core: consumes the EX/MEM pipeline register (ALU result, store data, memory controls) and produces the MEM/WB register contents. It performs byte-lane alignment for stores and extraction plus sign/zero extension for loads. It runs a request/acknowledge handshake with a variable-latency data memory and stalls the upstream pipeline until each access completes. Its registered result is the value the EX stage forwards from MEM/WB.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting for `dmem_ack_i` before the access is abandoned (1..255)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_mem_valid_i  in  1  EX/MEM slot holds a live instruction
- ex_mem_alu_result_i  in  32  ALU result; byte address for loads/stores
- ex_mem_rs2_data_i  in  32  store data (forwarded rs2)
- ex_mem_mem_read_i / ex_mem_mem_write_i  in  1  load / store (never both)
- ex_mem_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W
- ex_mem_rd_addr_i  in  5  destination register
- ex_mem_reg_write_i  in  1  register write enable
- dmem_req_o  out  1  access request, held until ack
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address (bits [1:0] = 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  access complete; rdata valid same cycle
- dmem_rdata_i  in  32  load word
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_wb_valid_o  out  1  MEM/WB slot valid
- mem_wb_result_o  out  32  load data or passed-through ALU result
- mem_wb_rd_addr_o  out  5  destination register
- mem_wb_reg_write_o  out  1  register write enable
- misalign_o  out  1  one-cycle pulse with the faulting instruction's MEM/WB slot
- timeout_o  out  1  one-cycle pulse with the abandoned access's MEM/WB slot

## Operation
- FSM states: IDLE, WAIT.
- IDLE, non-memory op (or valid=0): inputs registered into MEM/WB next edge; `mem_wb_valid_o` = `ex_mem_valid_i`; `stall_o` = 0.
- IDLE, aligned load/store with valid=1: `stall_o` = 1 combinationally. Address, controls, byte enables and store data captured. Next edge → WAIT with `dmem_req_o` = 1. MEM/WB gets a bubble (valid 0, reg_write 0).
- Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=0. A misaligned access issues no bus request and passes through in one cycle with `misalign_o`=1, `reg_write` forced 0, and result = address.
- Store lanes: B: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}. H: be = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}. W: be = 1111.
- Load extract: shift `dmem_rdata_i` right by 8·addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU). Loads drive be per size as well.
- WAIT: `stall_o` = !dmem_ack_i. On the ack cycle: next edge MEM/WB loaded (valid 1, load data or 0 for stores, reg_write as captured), `dmem_req_o` drops, FSM → IDLE. Upstream advances on that same edge.
- Timeout: an 8-bit counter clears on entering WAIT and increments each WAIT cycle without ack. When count reaches TIMEOUT_CYCLES-1 with no ack: `stall_o`=0, and the slot retires with `timeout_o`=1, reg_write 0, result 0. FSM → IDLE.
- Ack and timeout in the same cycle: ack wins. Ack in IDLE: ignored.

## Timing
- Reset values: FSM IDLE, counter 0, every output 0 (`stall_o` 0 while rst is high).
- Non-memory / misaligned latency: 1 cycle.
- Memory latency: 1 + N cycles, where N ≥ 1 is the cycle count from req rise to ack inclusive. Minimum 2.
- `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `dmem_we_o` are registered and stable for the whole time `dmem_req_o` is high.
- Reset mid-WAIT: the request drops asynchronously. A subsequent stray ack is ignored.
- `mem_wb_result_o` is registered, with no combinational path from `dmem_rdata_i` to any output except through `stall_o` (from ack).

## Structure
- Shared defines header (alongside the ALU op defines): funct3 size encodings and FSM state encodings.
- Sub-module `lsu_align`: combinational. Computes misalign detection, byte enables, store replication and load extraction/extension. Instanced once.
- Top of `mem_stage`: FSM, timeout counter, capture registers and MEM/WB registers.

## Test plan
- ALU op addi, result 0x0000_1234, rd=5 -> next cycle mem_wb_valid 1, result 0x1234, rd 5, stall never high.
- SB to 0x103 with rs2=0xAABBCCDD, ack 3 cycles after req -> be 1000, wdata 0xDDDDDDDD, addr 0x100, stall high 3 cycles, then MEM/WB valid with reg_write 0.
- LB from 0x102, rdata 0x0080_0000, ack first req cycle -> result 0xFFFF_FF80. Same with LBU -> 0x0000_0080. Total 2 cycles.
- LW at 0x202 -> no req, misalign_o pulse, reg_write 0, 1-cycle latency.
- LW, ack withheld, TIMEOUT_CYCLES=4 -> req high 4 cycles then drops, timeout_o pulse, result 0.
- rst asserted 2 cycles into WAIT -> req, stall and all outputs 0 immediately. Ack the next cycle is ignored and FSM stays IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load/store size encodings and FSM states.
package mem_stage_pkg;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

   typedef enum logic {StIdle, StWait} mem_state_e;

   // Unlisted funct3 encodings behave as full-word accesses.
   function automatic mem_size_e decode_size(input logic [2:0] funct3);
      case (funct3)
         F3Byte, F3ByteU: return SzByte;
         F3Half, F3HalfU: return SzHalf;
         F3Word:          return SzWord;
         default:         return SzWord;
      endcase
   endfunction

   function automatic logic is_signed_load(input logic [2:0] funct3);
      return !funct3[2];
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the MEM stage: misalignment, byte enables, store
// replication and load extraction with sign/zero extension.
module lsu_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_word_i,
   output logic        misalign_o,
   output logic [3:0]  byte_en_o,
   output logic [31:0] store_wdata_o,
   output logic [31:0] load_data_o
);

   mem_size_e   size;
   logic        sext;
   logic [31:0] shifted;

   always_comb begin
      size          = decode_size(funct3_i);
      sext          = is_signed_load(funct3_i);
      shifted       = load_word_i >> {addr_lo_i, 3'b000};
      misalign_o    = 1'b0;
      byte_en_o     = 4'b1111;
      store_wdata_o = store_data_i;
      load_data_o   = shifted;
      case (size)
         SzByte: begin
            byte_en_o     = 4'b0001 << addr_lo_i;
            store_wdata_o = {4{store_data_i[7:0]}};
            load_data_o   = {{24{sext & shifted[7]}}, shifted[7:0]};
         end
         SzHalf: begin
            misalign_o    = addr_lo_i[0];
            byte_en_o     = 4'b0011 << addr_lo_i;
            store_wdata_o = {2{store_data_i[15:0]}};
            load_data_o   = {{16{sext & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            misalign_o    = |addr_lo_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack data memory, stalls upstream while an
// access is outstanding and produces the registered MEM/WB slot.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_valid_i,
   input  logic [31:0] ex_mem_alu_result_i,
   input  logic [31:0] ex_mem_rs2_data_i,
   input  logic        ex_mem_mem_read_i,
   input  logic        ex_mem_mem_write_i,
   input  logic [2:0]  ex_mem_funct3_i,
   input  logic [4:0]  ex_mem_rd_addr_i,
   input  logic        ex_mem_reg_write_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic        mem_wb_valid_o,
   output logic [31:0] mem_wb_result_o,
   output logic [4:0]  mem_wb_rd_addr_o,
   output logic        mem_wb_reg_write_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e  state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic        rw_q;
   logic        req_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        wb_valid_q;
   logic [31:0] wb_result_q;
   logic [4:0]  wb_rd_q;
   logic        wb_rw_q;
   logic        mis_q;
   logic        to_q;

   logic        in_wait;
   logic        is_mem;
   logic        start;
   logic        to_fire;
   logic [1:0]  lsu_off;
   logic [2:0]  lsu_funct3;
   logic        lsu_misalign;
   logic [3:0]  lsu_be;
   logic [31:0] lsu_wdata;
   logic [31:0] lsu_load;

   assign in_wait = (state_q == StWait);
   assign is_mem  = ex_mem_valid_i & (ex_mem_mem_read_i | ex_mem_mem_write_i);
   assign start   = !in_wait & is_mem & !lsu_misalign;
   assign to_fire = in_wait & !dmem_ack_i & (cnt_q == TimeoutLast);
   assign stall_o = !rst & (start | (in_wait & !dmem_ack_i & !to_fire));

   // One aligner serves both phases: request setup in IDLE, load extraction in WAIT.
   assign lsu_off    = in_wait ? addr_q[1:0] : ex_mem_alu_result_i[1:0];
   assign lsu_funct3 = in_wait ? funct3_q : ex_mem_funct3_i;

   lsu_align u_lsu_align (
      .addr_lo_i     (lsu_off),
      .funct3_i      (lsu_funct3),
      .store_data_i  (ex_mem_rs2_data_i),
      .load_word_i   (dmem_rdata_i),
      .misalign_o    (lsu_misalign),
      .byte_en_o     (lsu_be),
      .store_wdata_o (lsu_wdata),
      .load_data_o   (lsu_load)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         addr_q      <= 32'd0;
         funct3_q    <= 3'd0;
         rd_q        <= 5'd0;
         rw_q        <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         wdata_q     <= 32'd0;
         wb_valid_q  <= 1'b0;
         wb_result_q <= 32'd0;
         wb_rd_q     <= 5'd0;
         wb_rw_q     <= 1'b0;
         mis_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         mis_q <= 1'b0;
         to_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (is_mem && lsu_misalign) begin
                  wb_valid_q  <= 1'b1;
                  wb_result_q <= ex_mem_alu_result_i;
                  wb_rd_q     <= ex_mem_rd_addr_i;
                  wb_rw_q     <= 1'b0;
                  mis_q       <= 1'b1;
               end else if (is_mem) begin
                  state_q     <= StWait;
                  cnt_q       <= 8'd0;
                  req_q       <= 1'b1;
                  we_q        <= ex_mem_mem_write_i;
                  addr_q      <= ex_mem_alu_result_i;
                  funct3_q    <= ex_mem_funct3_i;
                  be_q        <= lsu_be;
                  wdata_q     <= lsu_wdata;
                  rd_q        <= ex_mem_rd_addr_i;
                  rw_q        <= ex_mem_reg_write_i;
                  wb_valid_q  <= 1'b0;
                  wb_result_q <= 32'd0;
                  wb_rd_q     <= 5'd0;
                  wb_rw_q     <= 1'b0;
               end else begin
                  wb_valid_q  <= ex_mem_valid_i;
                  wb_result_q <= ex_mem_alu_result_i;
                  wb_rd_q     <= ex_mem_rd_addr_i;
                  wb_rw_q     <= ex_mem_reg_write_i;
               end
            end
            StWait: begin
               if (dmem_ack_i) begin
                  state_q     <= StIdle;
                  req_q       <= 1'b0;
                  wb_valid_q  <= 1'b1;
                  wb_result_q <= we_q ? 32'd0 : lsu_load;
                  wb_rd_q     <= rd_q;
                  wb_rw_q     <= rw_q;
               end else if (cnt_q == TimeoutLast) begin
                  state_q     <= StIdle;
                  req_q       <= 1'b0;
                  wb_valid_q  <= 1'b1;
                  wb_result_q <= 32'd0;
                  wb_rd_q     <= rd_q;
                  wb_rw_q     <= 1'b0;
                  to_q        <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmem_req_o         = req_q;
   assign dmem_we_o          = we_q;
   assign dmem_addr_o        = {addr_q[31:2], 2'b00};
   assign dmem_be_o          = be_q;
   assign dmem_wdata_o       = wdata_q;
   assign mem_wb_valid_o     = wb_valid_q;
   assign mem_wb_result_o    = wb_result_q;
   assign mem_wb_rd_addr_o   = wb_rd_q;
   assign mem_wb_reg_write_o = wb_rw_q;
   assign misalign_o         = mis_q;
   assign timeout_o          = to_q;

endmodule
